pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core; drives stall[5:0] to pc_reg, if_id, id_ex, ex_mem, mem_wb.
- Merges stall requests from the ID, EX and MEM stages, sequences exception/ERET flushes with the redirect PC, and runs a debug halt handshake.
- Also keeps a stall watchdog and a stall-cycle performance counter.

Parameters:
- EXC_VECTOR, 32'h00000040, redirect target for every non-ERET exception.
- STALL_TIMEOUT, 16'd1024, count of consecutive stalled cycles that sets the watchdog flag; valid range 1..65535.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- stallreq_from_id_i  in  1  ID needs a stall (load-use hazard).
- stallreq_from_ex_i  in  1  EX needs a stall (multi-cycle mul/div).
- stallreq_from_mem_i  in  1  MEM needs a stall (data bus wait).
- excepttype_i  in  32  exception code from MEM; 0 means none.
- cp0_epc_i  in  32  EPC from CP0.
- halt_req_i  in  1  debug halt request, level.
- stall_o  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold.
- flush_o  out  1  registered flush pulse to all pipeline registers.
- new_pc_o  out  32  redirect PC; valid only while flush_o=1.
- halt_ack_o  out  1  pipeline frozen for debug.
- stall_timeout_o  out  1  sticky watchdog flag.
- stall_cycles_o  out  32  count of cycles with stall_o!=0; wraps modulo 2^32.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, stall_o=0, flush_o=0, new_pc_o=0, halt_ack_o=0, stall_timeout_o=0, stall_cycles_o=0, watchdog count=0.
- States:
  - RUN: normal operation.
  - FLUSH: one cycle.
  - RECOVER: one cycle.
  - HALT_WAIT: waiting for the pipeline to drain before halting.
  - HALTED: pipeline frozen.
- stall_o is combinational from the request inputs and state. Highest priority first:
  - state FLUSH or RECOVER: 6'b000000.
  - state HALTED: 6'b111111.
  - stallreq_from_mem_i: 6'b011111.
  - stallreq_from_ex_i: 6'b001111.
  - stallreq_from_id_i: 6'b000111.
  - otherwise: 6'b000000.
- Exception, accepted in RUN or HALT_WAIT when excepttype_i!=0:
  - Next edge: state=FLUSH, flush_o=1.
  - new_pc_o=cp0_epc_i when excepttype_i==32'h0000000e (ERET); otherwise EXC_VECTOR.
  - An exception takes priority over a halt request in the same cycle.
- FLUSH: one cycle, then RECOVER. In RECOVER, excepttype_i is ignored (squashed instructions), flush_o=0, new_pc_o=0. RECOVER then goes to RUN, or to HALT_WAIT if halt_req_i=1.
- Halt handshake:
  - RUN with halt_req_i=1 goes to HALT_WAIT.
  - HALT_WAIT goes to HALTED on the first cycle where all three stall requests are 0 and excepttype_i==0. halt_ack_o=1 from the HALTED entry edge.
  - HALTED with halt_req_i=0 goes to RUN; halt_ack_o falls on that edge.
  - halt_req_i dropping during HALT_WAIT returns to RUN with no ack.
- Exceptions presented while HALTED are ignored; the pipeline is frozen.
- Watchdog:
  - 16-bit count increments each cycle any stall request is 1 and state is RUN or HALT_WAIT; otherwise it clears to 0.
  - The count saturates at STALL_TIMEOUT; reaching it sets stall_timeout_o=1 until reset.
- stall_cycles_o increments on every edge where stall_o!=0, including HALTED, and wraps from FFFFFFFF to 0.
- Reset asserted mid-flush or mid-halt returns immediately to reset values. No pending exception or halt survives reset.

Test Plan:
- Reset release, then stallreq_from_ex_i=1 for 3 cycles -> stall_o=6'b001111 in those cycles, then 0; stall_cycles_o=3.
- stallreq_from_id_i=1 and stallreq_from_mem_i=1 together -> stall_o=6'b011111 (MEM wins).
- excepttype_i=32'h8 for 1 cycle -> next cycle flush_o=1, new_pc_o=32'h00000040, stall_o=0. Following cycle flush_o=0. An excepttype_i=32'h8 during RECOVER produces no second flush.
- excepttype_i=32'he, cp0_epc_i=32'h00001234 -> flush_o=1, new_pc_o=32'h00001234.
- halt_req_i=1 while stallreq_from_mem_i=1 for 2 cycles -> halt_ack_o stays 0 until the request clears. halt_ack_o=1 one edge later with stall_o=6'b111111. Dropping halt_req_i -> halt_ack_o=0 and stall_o=0 next cycle.
- STALL_TIMEOUT=4, stallreq_from_ex_i held high -> stall_timeout_o=1 after the 4th stalled edge, and stays 1 after the request drops; asserting rst=0 clears it.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module  : pipe_ctrl_if
// Brief   : Stall/flush/halt bundle between pipe_ctrl and the pipeline stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;
  logic        stallreq_from_id_i;
  logic        stallreq_from_ex_i;
  logic        stallreq_from_mem_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        halt_req_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        halt_ack_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  // master: the controller itself; slave: the pipeline / debug side
  modport master (
    input  stallreq_from_id_i, stallreq_from_ex_i, stallreq_from_mem_i,
    input  excepttype_i, cp0_epc_i, halt_req_i,
    output stall_o, flush_o, new_pc_o, halt_ack_o,
    output stall_timeout_o, stall_cycles_o
  );

  modport slave (
    output stallreq_from_id_i, stallreq_from_ex_i, stallreq_from_mem_i,
    output excepttype_i, cp0_epc_i, halt_req_i,
    input  stall_o, flush_o, new_pc_o, halt_ack_o,
    input  stall_timeout_o, stall_cycles_o
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Brief   : 5-stage pipeline controller: stall merge, exception/ERET flush,
//           debug halt handshake, stall watchdog and stall-cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus
);

  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    FLUSH     = 3'd1,
    RECOVER   = 3'd2,
    HALT_WAIT = 3'd3,
    HALTED    = 3'd4
  } state_t;

  state_t      state;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic        halt_ack_q;
  logic        timeout_q;
  logic [31:0] cycles_q;
  logic [15:0] wd_cnt;
  logic [5:0]  stall;
  logic        any_req;
  logic        exc_pending;
  logic        wd_active;

  assign any_req     = bus.stallreq_from_id_i | bus.stallreq_from_ex_i | bus.stallreq_from_mem_i;
  assign exc_pending = (bus.excepttype_i != 32'd0);
  assign wd_active   = any_req && ((state == RUN) || (state == HALT_WAIT));

  always_comb begin
    stall = 6'b000000;
    if ((state == FLUSH) || (state == RECOVER))
      stall = 6'b000000;
    else if (state == HALTED)
      stall = 6'b111111;
    else if (bus.stallreq_from_mem_i)
      stall = 6'b011111;
    else if (bus.stallreq_from_ex_i)
      stall = 6'b001111;
    else if (bus.stallreq_from_id_i)
      stall = 6'b000111;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      flush_q    <= 1'b0;
      new_pc_q   <= 32'd0;
      halt_ack_q <= 1'b0;
      timeout_q  <= 1'b0;
      cycles_q   <= 32'd0;
      wd_cnt     <= 16'd0;
    end else begin
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;

      case (state)
        RUN, HALT_WAIT: begin
          // Exceptions outrank halt, so a halt never freezes a faulting pipe
          if (exc_pending) begin
            state    <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
          end else if (!bus.halt_req_i) begin
            state <= RUN;
          end else if ((state == HALT_WAIT) && !any_req) begin
            state      <= HALTED;
            halt_ack_q <= 1'b1;
          end else begin
            state <= HALT_WAIT;
          end
        end
        FLUSH:   state <= RECOVER;
        RECOVER: state <= bus.halt_req_i ? HALT_WAIT : RUN;
        HALTED: begin
          if (!bus.halt_req_i) begin
            state      <= RUN;
            halt_ack_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase

      if (wd_active) begin
        if (wd_cnt < STALL_TIMEOUT)
          wd_cnt <= wd_cnt + 16'd1;
        if (wd_cnt >= STALL_TIMEOUT - 16'd1)
          timeout_q <= 1'b1;
      end else begin
        wd_cnt <= 16'd0;
      end

      if (stall != 6'b000000)
        cycles_q <= cycles_q + 32'd1;
    end
  end

  assign bus.stall_o         = stall;
  assign bus.flush_o         = flush_q;
  assign bus.new_pc_o        = new_pc_q;
  assign bus.halt_ack_o      = halt_ack_q;
  assign bus.stall_timeout_o = timeout_q;
  assign bus.stall_cycles_o  = cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module  : tb_pipe_ctrl
// Brief   : Directed scenarios plus randomized run against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;
  localparam logic [31:0] EXC_VEC = 32'h0000_0040;
  localparam int          TO      = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .STALL_TIMEOUT(16'(TO))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: halt status as two flags, post-exception blind window as a countdown
  bit          m_halted, m_waiting, m_ack, m_to, m_flush;
  int          m_blind, m_wd;
  logic [31:0] m_newpc, m_cyc;

  function automatic logic [5:0] m_stall();
    if (m_blind > 0)             return 6'h00;
    if (m_halted)                return 6'h3f;
    if (bus.stallreq_from_mem_i) return 6'h1f;
    if (bus.stallreq_from_ex_i)  return 6'h0f;
    if (bus.stallreq_from_id_i)  return 6'h07;
    return 6'h00;
  endfunction

  task automatic m_reset();
    m_halted = 0; m_waiting = 0; m_ack = 0; m_to = 0; m_flush = 0;
    m_blind = 0; m_wd = 0; m_newpc = 0; m_cyc = 0;
  endtask

  task automatic m_edge();
    bit any;
    bit nf;
    logic [31:0] npc;
    any = bus.stallreq_from_id_i | bus.stallreq_from_ex_i | bus.stallreq_from_mem_i;
    if (m_stall() != 0) m_cyc = m_cyc + 1;
    if (any && m_blind == 0 && !m_halted) begin
      m_wd = (m_wd + 1 > TO) ? TO : m_wd + 1;
      if (m_wd == TO) m_to = 1;
    end else m_wd = 0;
    nf = 0; npc = 0;
    if (m_blind == 2) m_blind = 1;
    else if (m_blind == 1) begin m_blind = 0; m_waiting = bus.halt_req_i; end
    else if (m_halted) begin
      if (!bus.halt_req_i) begin m_halted = 0; m_ack = 0; end
    end else if (bus.excepttype_i != 0) begin
      m_blind = 2; m_waiting = 0; nf = 1;
      npc = (bus.excepttype_i == 32'he) ? bus.cp0_epc_i : EXC_VEC;
    end else if (!bus.halt_req_i) m_waiting = 0;
    else if (m_waiting && !any) begin m_waiting = 0; m_halted = 1; m_ack = 1; end
    else m_waiting = 1;
    m_flush = nf; m_newpc = npc;
  endtask

  task automatic set_in(bit id, bit ex, bit mem, logic [31:0] exc, logic [31:0] epc, bit halt);
    bus.stallreq_from_id_i  = id;
    bus.stallreq_from_ex_i  = ex;
    bus.stallreq_from_mem_i = mem;
    bus.excepttype_i        = exc;
    bus.cp0_epc_i           = epc;
    bus.halt_req_i          = halt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    #2;
    m_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    set_in(0, 1, 1, 32'h8, 32'h0, 1);
    do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    tests++;
    if ({bus.stall_o, bus.flush_o, bus.new_pc_o, bus.halt_ack_o, bus.stall_timeout_o, bus.stall_cycles_o} !== 72'd0) begin
      fails++;
      $display("FAIL reset_values: got stall=%h flush=%b pc=%h ack=%b to=%b cyc=%0d want all zero",
               bus.stall_o, bus.flush_o, bus.new_pc_o, bus.halt_ack_o, bus.stall_timeout_o, bus.stall_cycles_o);
    end
  endtask

  task automatic test_ex_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 0, 0, 0); #1;
      tests++;
      if (bus.stall_o !== 6'b001111) begin fails++; $display("FAIL ex_stall[%0d]: got %b want 001111", i, bus.stall_o); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0); #1;
    tests++;
    if (bus.stall_o !== 6'b000000) begin fails++; $display("FAIL ex_stall_end: got %b want 000000", bus.stall_o); end
    tick();
    tests++;
    if (bus.stall_cycles_o !== 32'd3) begin fails++; $display("FAIL stall_cycles: got %0d want 3", bus.stall_cycles_o); end
  endtask

  task automatic test_priority();
    do_reset();
    set_in(1, 0, 1, 0, 0, 0); #1;
    tests++;
    if (bus.stall_o !== 6'b011111) begin fails++; $display("FAIL prio_mem: got %b want 011111", bus.stall_o); end
    set_in(1, 0, 0, 0, 0, 0); #1;
    tests++;
    if (bus.stall_o !== 6'b000111) begin fails++; $display("FAIL prio_id: got %b want 000111", bus.stall_o); end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_exception();
    do_reset();
    set_in(0, 0, 0, 32'h8, 32'h5555, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0); #1;
    tests++;
    if ({bus.flush_o, bus.new_pc_o, bus.stall_o} !== {1'b1, EXC_VEC, 6'b0}) begin
      fails++; $display("FAIL exc_flush: got flush=%b pc=%h stall=%b want 1 %h 0", bus.flush_o, bus.new_pc_o, bus.stall_o, EXC_VEC);
    end
    tick();
    tests++;
    if ({bus.flush_o, bus.new_pc_o} !== 33'd0) begin fails++; $display("FAIL exc_recover: got flush=%b pc=%h want 0 0", bus.flush_o, bus.new_pc_o); end
    set_in(0, 0, 0, 32'h8, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tests++;
    if (bus.flush_o !== 1'b0) begin fails++; $display("FAIL exc_in_recover: got flush=%b want 0", bus.flush_o); end
  endtask

  task automatic test_eret();
    do_reset();
    set_in(0, 0, 0, 32'he, 32'h1234, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tests++;
    if ({bus.flush_o, bus.new_pc_o} !== {1'b1, 32'h1234}) begin
      fails++; $display("FAIL eret: got flush=%b pc=%h want 1 00001234", bus.flush_o, bus.new_pc_o);
    end
    tick(); tick();
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 1, 0, 0, 1);
      tick();
      tests++;
      if (bus.halt_ack_o !== 1'b0) begin fails++; $display("FAIL halt_wait[%0d]: got ack=%b want 0", i, bus.halt_ack_o); end
    end
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    tests++;
    if ({bus.halt_ack_o, bus.stall_o} !== {1'b1, 6'b111111}) begin
      fails++; $display("FAIL halted: got ack=%b stall=%b want 1 111111", bus.halt_ack_o, bus.stall_o);
    end
    set_in(0, 0, 0, 32'h8, 0, 1);
    tick();
    tests++;
    if ({bus.flush_o, bus.halt_ack_o} !== 2'b01) begin
      fails++; $display("FAIL halted_exc: got flush=%b ack=%b want 0 1", bus.flush_o, bus.halt_ack_o);
    end
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    tests++;
    if ({bus.halt_ack_o, bus.stall_o} !== 7'd0) begin
      fails++; $display("FAIL unhalt: got ack=%b stall=%b want 0 000000", bus.halt_ack_o, bus.stall_o);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_in(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= TO; i++) begin
      tick();
      tests++;
      if (bus.stall_timeout_o !== (i == TO)) begin
        fails++; $display("FAIL wd_edge%0d: got %b want %b", i, bus.stall_timeout_o, (i == TO));
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
    tick(); tick();
    tests++;
    if (bus.stall_timeout_o !== 1'b1) begin fails++; $display("FAIL wd_sticky: got %b want 1", bus.stall_timeout_o); end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (bus.stall_timeout_o !== 1'b0) begin fails++; $display("FAIL wd_reset: got %b want 0", bus.stall_timeout_o); end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] exc;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      case ($urandom_range(0, 9))
        0:       exc = 32'he;
        1:       exc = $urandom;
        default: exc = 32'h0;
      endcase
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             exc, $urandom, $urandom_range(0, 2) != 0);
      #1;
      tests++;
      if (bus.stall_o !== m_stall()) begin
        fails++; $display("FAIL rand_stall@%0d: got %b want %b", c, bus.stall_o, m_stall());
      end
      m_edge();
      tick();
      tests++;
      if ({bus.flush_o, bus.new_pc_o, bus.halt_ack_o, bus.stall_timeout_o, bus.stall_cycles_o}
          !== {m_flush, m_newpc, m_ack, m_to, m_cyc}) begin
        fails++;
        $display("FAIL rand_regs@%0d: got flush=%b pc=%h ack=%b to=%b cyc=%0d want %b %h %b %b %0d", c,
                 bus.flush_o, bus.new_pc_o, bus.halt_ack_o, bus.stall_timeout_o, bus.stall_cycles_o,
                 m_flush, m_newpc, m_ack, m_to, m_cyc);
      end
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    m_reset();
    test_reset();
    test_ex_stall();
    test_priority();
    test_exception();
    test_eret();
    test_halt();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
